// File: rtl/my_project.sv
// Fixed-point 2-4-1 fully connected inference core (ReLU hidden, linear output).
// Three register stages: input capture, hidden layer, output layer; II = 1.
module my_project #(
    parameter logic [143:0] W1 = {18'h00100, 18'h00200, 18'h00400, 18'h3FC00,
                                  18'h3FC00, 18'h00400, 18'h00400, 18'h00400},
    parameter logic [71:0]  B1 = '0,
    parameter logic [71:0]  W2 = {18'h00800, 18'h3FC00, 18'h00400, 18'h00200},
    parameter logic [17:0]  B2 = '0
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic        input_2_V_ap_vld,
    input  logic [35:0] input_2_V,
    output logic [17:0] layer7_out_0_V,
    output logic        layer7_out_0_V_ap_vld
);

    // Clamp a wide signed value into the signed 18-bit range.
    function automatic logic [17:0] sat18(input logic signed [39:0] v);
        if (v > 40'sd131071)
            return 18'h1FFFF;
        else if (v < -40'sd131072)
            return 18'h20000;
        else
            return v[17:0];
    endfunction

    logic signed [17:0] x0_q;
    logic signed [17:0] x1_q;
    logic               v0;
    logic signed [17:0] hid_next [4];
    logic signed [17:0] hid_q    [4];
    logic               v1;
    logic [17:0]        out_next;

    for (genvar i = 0; i < 4; i++) begin : g_hidden
        logic signed [17:0] w_a;
        logic signed [17:0] w_b;
        logic signed [17:0] bias;
        logic signed [35:0] p_a;
        logic signed [35:0] p_b;
        logic signed [39:0] acc;
        logic signed [39:0] shifted;
        logic        [17:0] clamped;

        assign w_a     = W1[36*i +: 18];
        assign w_b     = W1[36*i+18 +: 18];
        assign bias    = B1[18*i +: 18];
        assign p_a     = 36'(w_a) * 36'(x0_q);
        assign p_b     = 36'(w_b) * 36'(x1_q);
        assign acc     = 40'(p_a) + 40'(p_b) + 40'(bias) * 40'sd1024;
        assign shifted = acc >>> 10;
        assign clamped = sat18(shifted);
        // ReLU after saturation: any negative result collapses to zero
        assign hid_next[i] = clamped[17] ? 18'sd0 : $signed(clamped);
    end

    logic signed [35:0] out_prod [4];

    for (genvar i = 0; i < 4; i++) begin : g_output
        logic signed [17:0] w_o;
        assign w_o         = W2[18*i +: 18];
        assign out_prod[i] = 36'(w_o) * 36'(hid_q[i]);
    end

    logic signed [39:0] out_acc;
    logic signed [39:0] out_shifted;

    assign out_acc = 40'(out_prod[0]) + 40'(out_prod[1]) + 40'(out_prod[2])
                   + 40'(out_prod[3]) + 40'($signed(B2)) * 40'sd1024;
    assign out_shifted = out_acc >>> 10;
    assign out_next    = sat18(out_shifted);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            x0_q                  <= '0;
            x1_q                  <= '0;
            v0                    <= 1'b0;
            v1                    <= 1'b0;
            layer7_out_0_V        <= '0;
            layer7_out_0_V_ap_vld <= 1'b0;
            for (int i = 0; i < 4; i++) hid_q[i] <= '0;
        end else begin
            v0                    <= ap_start && input_2_V_ap_vld;
            v1                    <= v0;
            layer7_out_0_V_ap_vld <= v1;
            if (ap_start && input_2_V_ap_vld) begin
                x0_q <= input_2_V[17:0];
                x1_q <= input_2_V[35:18];
            end
            if (v0) begin
                for (int i = 0; i < 4; i++) hid_q[i] <= hid_next[i];
            end
            // Output data holds its last result between valid pulses
            if (v1)
                layer7_out_0_V <= out_next;
        end
    end

    assign ap_done  = layer7_out_0_V_ap_vld;
    assign ap_ready = ap_start;
    assign ap_idle  = !ap_start && !v0 && !v1 && !layer7_out_0_V_ap_vld;

endmodule

// File: tb/tb_my_project.sv
// Scoreboard bench for my_project: directed vectors push expected results,
// a monitor pops and compares on every valid pulse.
module tb_my_project;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic        input_2_V_ap_vld;
    logic [35:0] input_2_V;
    logic [17:0] layer7_out_0_V;
    logic        layer7_out_0_V_ap_vld;

    my_project dut (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .ap_start              (ap_start),
        .ap_done               (ap_done),
        .ap_idle               (ap_idle),
        .ap_ready              (ap_ready),
        .input_2_V_ap_vld      (input_2_V_ap_vld),
        .input_2_V             (input_2_V),
        .layer7_out_0_V        (layer7_out_0_V),
        .layer7_out_0_V_ap_vld (layer7_out_0_V_ap_vld)
    );

    typedef struct {
        logic [17:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [17:0] actual,
                                input logic [17:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%05h), expected %0d (0x%05h)",
                     name, $signed(actual), actual, $signed(expected), expected);
        end
    endtask

    // Issue one accepted sample at a falling edge; result is due three edges later
    task automatic apply_stimulus(input logic signed [17:0] x0,
                                  input logic signed [17:0] x1,
                                  input logic signed [17:0] expected);
        exp_t e;
        ap_start         = 1'b1;
        input_2_V_ap_vld = 1'b1;
        input_2_V        = {x1, x0};
        e.data           = expected;
        e.cyc            = cycle + 3;
        sb.push_back(e);
        @(negedge ap_clk);
    endtask

    task automatic drive_idle(input int n);
        ap_start         = 1'b0;
        input_2_V_ap_vld = 1'b0;
        repeat (n) @(negedge ap_clk);
    endtask

    // Monitor: every falling edge, compare presented results against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge ap_clk);
            check_output("done_eq_vld", 18'(ap_done), 18'(layer7_out_0_V_ap_vld));
            if (layer7_out_0_V_ap_vld) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: got vld=1 with out=0x%05h, expected no pulse",
                             layer7_out_0_V);
                end else begin
                    e = sb.pop_front();
                    check_output("result", layer7_out_0_V, e.data);
                    check_output("latency", 18'(cycle), 18'(e.cyc));
                end
            end
        end
    end

    initial begin
        ap_rst_n         = 1'b0;
        ap_start         = 1'b0;
        input_2_V_ap_vld = 1'b0;
        input_2_V        = '0;
        repeat (2) @(negedge ap_clk);
        check_output("reset_out", layer7_out_0_V, 18'd0);
        check_output("reset_vld", 18'(layer7_out_0_V_ap_vld), 18'd0);
        check_output("reset_idle", 18'(ap_idle), 18'd1);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        ap_start = 1'b1;
        #1;
        check_output("ready_hi", 18'(ap_ready), 18'd1);
        check_output("idle_start", 18'(ap_idle), 18'd0);
        ap_start = 1'b0;
        #1;
        check_output("ready_lo", 18'(ap_ready), 18'd0);
        check_output("idle_empty", 18'(ap_idle), 18'd1);
        @(negedge ap_clk);

        // Single samples: basic, negative, ReLU zeros, saturation, floor rounding
        apply_stimulus(18'sd1024, 18'sd512, 18'sd2560);
        drive_idle(0);
        #1;
        check_output("idle_inflight", 18'(ap_idle), 18'd0);
        drive_idle(4);
        apply_stimulus(-18'sd1024, 18'sd1024, -18'sd2048);
        drive_idle(4);
        apply_stimulus(-18'sd1024, -18'sd1024, 18'sd0);
        drive_idle(4);
        apply_stimulus(18'sd102400, 18'sd102400, 18'sd131071);
        drive_idle(4);
        apply_stimulus(18'sd1, 18'sd0, 18'sd1);
        drive_idle(4);
        apply_stimulus(18'sd0, 18'sd1, -18'sd1);
        drive_idle(4);

        // Back-to-back stream of four samples
        apply_stimulus(-18'sd1, 18'sd0, -18'sd1);
        apply_stimulus(-18'sd102400, 18'sd102400, -18'sd131071);
        apply_stimulus(18'sd1024, 18'sd512, 18'sd2560);
        apply_stimulus(-18'sd1024, 18'sd1024, -18'sd2048);
        drive_idle(5);
        check_output("hold_last", layer7_out_0_V, 18'h3F800);

        // Valid without start must be ignored
        ap_start         = 1'b0;
        input_2_V_ap_vld = 1'b1;
        input_2_V        = {18'sd512, 18'sd1024};
        @(negedge ap_clk);
        check_output("idle_gated", 18'(ap_idle), 18'd1);
        @(negedge ap_clk);
        drive_idle(4);
        check_output("hold_gated", layer7_out_0_V, 18'h3F800);

        // Reset while a sample sits in the hidden stage discards it
        apply_stimulus(18'sd1024, 18'sd512, 18'sd2560);
        drive_idle(1);
        ap_rst_n = 1'b0;
        sb.delete();
        #1;
        check_output("midrst_out", layer7_out_0_V, 18'd0);
        check_output("midrst_vld", 18'(layer7_out_0_V_ap_vld), 18'd0);
        check_output("midrst_idle", 18'(ap_idle), 18'd1);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        drive_idle(4);
        check_output("post_rst_out", layer7_out_0_V, 18'd0);
        apply_stimulus(18'sd102400, 18'sd102400, 18'sd131071);
        drive_idle(5);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d results outstanding, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
